// File: rtl/parity2d_frame_decoder.sv
// Serial receiver for 16-bit words protected by 4x4 two-dimensional even parity.
// Shifts in a 24-bit {c,r,d} frame LSB first, corrects single data-bit errors, reports status.
module parity2d_frame_decoder #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [15:0]      data_out,
  output logic             out_valid,
  output logic [1:0]       status,
  output logic [4:0]       err_pos,
  output logic             frame_abort,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // gap_q never exceeds TIMEOUT-1
  localparam int unsigned GapW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [23:0]      frame_q, frame_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [3:0]       rs_q, rs_d, cs_q, cs_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       status_q, status_d;
  logic [4:0]       err_pos_q, err_pos_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] corr_q, corr_d, uncorr_q, uncorr_d;

  logic [15:0] rx_d;
  logic [3:0]  rx_r, rx_c, row_par, col_par;
  logic        accept;

  assign rx_d = frame_q[15:0];
  assign rx_r = frame_q[19:16];
  assign rx_c = frame_q[23:20];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      row_par[i] = ^rx_d[4*i +: 4];
      col_par[i] = rx_d[i] ^ rx_d[i+4] ^ rx_d[i+8] ^ rx_d[i+12];
    end
  end

  // Classification from the registered syndromes, valid while in StDone
  logic        rs_one, cs_one;
  logic [1:0]  row_idx, col_idx;
  logic [15:0] dec_data;
  logic [1:0]  dec_status;
  logic [4:0]  dec_pos;

  always_comb begin
    rs_one  = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
    cs_one  = (cs_q != 4'd0) && ((cs_q & (cs_q - 4'd1)) == 4'd0);
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rs_q[i]) row_idx = 2'(i);
      if (cs_q[i]) col_idx = 2'(i);
    end
    dec_data   = rx_d;
    dec_status = 2'b11;
    dec_pos    = 5'd31;
    if (rs_q == 4'd0 && cs_q == 4'd0) begin
      dec_status = 2'b00;
    end else if (rs_one && cs_one) begin
      dec_data   = rx_d ^ (16'h0001 << {row_idx, col_idx});
      dec_status = 2'b01;
      dec_pos    = {3'b000, row_idx, col_idx};
    end else if (rs_one && cs_q == 4'd0) begin
      dec_status = 2'b10;
      dec_pos    = {3'b100, row_idx};
    end else if (rs_q == 4'd0 && cs_one) begin
      dec_status = 2'b10;
      dec_pos    = 5'd20 + {3'b000, col_idx};
    end
  end

  assign bit_ready   = (state_q == StIdle) || (state_q == StRecv);
  assign accept      = bit_valid && bit_ready;
  assign out_valid   = (state_q == StDone);
  assign data_out    = out_valid ? dec_data   : data_q;
  assign status      = out_valid ? dec_status : status_q;
  assign err_pos     = out_valid ? dec_pos    : err_pos_q;
  assign frame_abort = abort_q;
  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = uncorr_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    rs_d      = rs_q;
    cs_d      = cs_q;
    data_d    = data_q;
    status_d  = status_q;
    err_pos_d = err_pos_q;
    abort_d   = 1'b0;
    corr_d    = corr_q;
    uncorr_d  = uncorr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          frame_d   = {23'd0, bit_in};
          bit_cnt_d = 5'd1;
          gap_d     = '0;
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (accept) begin
          frame_d[bit_cnt_q] = bit_in;
          gap_d              = '0;
          if (bit_cnt_q == 5'd23) begin
            state_d = StCheck;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (gap_q == GapW'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StCheck: begin
        rs_d    = rx_r ^ row_par;
        cs_d    = rx_c ^ col_par;
        state_d = StDone;
      end
      StDone: begin
        data_d    = dec_data;
        status_d  = dec_status;
        err_pos_d = dec_pos;
        if (dec_status == 2'b11) begin
          if (uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
        end else if (dec_status != 2'b00) begin
          if (corr_q != '1) corr_d = corr_q + CNT_W'(1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      rs_q      <= '0;
      cs_q      <= '0;
      data_q    <= '0;
      status_q  <= 2'b00;
      err_pos_q <= 5'd31;
      abort_q   <= 1'b0;
      corr_q    <= '0;
      uncorr_q  <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      rs_q      <= rs_d;
      cs_q      <= cs_d;
      data_q    <= data_d;
      status_q  <= status_d;
      err_pos_q <= err_pos_d;
      abort_q   <= abort_d;
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
    end
  end

endmodule

// File: tb/tb_parity2d_frame_decoder.sv
// Directed bench for parity2d_frame_decoder: decode cases, latency, timeout, reset, saturation.
module tb_parity2d_frame_decoder;

  localparam int unsigned Timeout = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [15:0] data_out;
  logic       out_valid;
  logic [1:0] status;
  logic [4:0] err_pos;
  logic       frame_abort;
  logic [7:0] corr_cnt;
  logic [7:0] uncorr_cnt;

  int n_total = 0;
  int n_bad   = 0;

  parity2d_frame_decoder #(
    .CNT_W  (8),
    .TIMEOUT(Timeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .status     (status),
    .err_pos    (err_pos),
    .frame_abort(frame_abort),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Sends the first n bits of f, LSB first; returns #1 after the edge accepting the last one
  task automatic send_bits(input logic [23:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard     = 0;
      bit_in    = f[i];
      bit_valid = 1'b1;
      while (!bit_ready && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!bit_ready) check("ready_wait", {31'd0, bit_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
  endtask

  task automatic decode(input string tag, input logic [23:0] f, input logic [15:0] exp_data,
                        input logic [1:0] exp_status, input logic [4:0] exp_pos);
    send_bits(f, 24);
    check({tag, "_valid_n1"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_chk"}, {31'd0, bit_ready}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid_n2"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, data_out}, {16'd0, exp_data});
    check({tag, "_status"}, {30'd0, status}, {30'd0, exp_status});
    check({tag, "_pos"}, {27'd0, err_pos}, {27'd0, exp_pos});
    @(posedge clk);
    #1;
    check({tag, "_valid_end"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hold"}, {16'd0, data_out}, {16'd0, exp_data});
  endtask

  initial begin
    int  cyc;
    logic seen_valid;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {16'd0, data_out}, 32'h0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_status", {30'd0, status}, 32'd0);
    check("rst_pos", {27'd0, err_pos}, 32'd31);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    check("rst_corr", {24'd0, corr_cnt}, 32'd0);
    check("rst_uncorr", {24'd0, uncorr_cnt}, 32'd0);
    check("rst_ready", {31'd0, bit_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    decode("clean", 24'h4D1234, 16'h1234, 2'b00, 5'd31);
    check("clean_corr", {24'd0, corr_cnt}, 32'd0);
    decode("d5", 24'h4D1214, 16'h1234, 2'b01, 5'd5);
    check("d5_corr", {24'd0, corr_cnt}, 32'd1);
    decode("r1", 24'h4F1234, 16'h1234, 2'b10, 5'd17);
    check("r1_corr", {24'd0, corr_cnt}, 32'd2);
    decode("c0", 24'h5D1234, 16'h1234, 2'b10, 5'd20);
    decode("d15", 24'h4D9234, 16'h1234, 2'b01, 5'd15);
    check("d15_corr", {24'd0, corr_cnt}, 32'd4);
    decode("d01", 24'h4D1237, 16'h1237, 2'b11, 5'd31);
    check("d01_uncorr", {24'd0, uncorr_cnt}, 32'd1);
    check("d01_corr", {24'd0, corr_cnt}, 32'd4);

    // Partial frame then silence: abort after exactly Timeout idle cycles
    send_bits(24'h4D1234, 10);
    cyc        = 0;
    seen_valid = 1'b0;
    while (!frame_abort && cyc < 3 * Timeout) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen_valid = 1'b1;
    end
    check("to_cycles", cyc, Timeout);
    check("to_no_valid", {31'd0, seen_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("to_pulse", {31'd0, frame_abort}, 32'd0);
    check("to_data_kept", {16'd0, data_out}, 32'h1237);
    check("to_status_kept", {30'd0, status}, 32'd3);
    check("to_uncorr_kept", {24'd0, uncorr_cnt}, 32'd1);
    decode("post_to", 24'h4D1234, 16'h1234, 2'b00, 5'd31);

    // Reset in the middle of a frame
    send_bits(24'h4D1214, 12);
    rst_n = 1'b0;
    #2;
    check("mid_rst_data", {16'd0, data_out}, 32'h0);
    check("mid_rst_pos", {27'd0, err_pos}, 32'd31);
    check("mid_rst_corr", {24'd0, corr_cnt}, 32'd0);
    check("mid_rst_uncorr", {24'd0, uncorr_cnt}, 32'd0);
    check("mid_rst_ready", {31'd0, bit_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    decode("post_rst", 24'h4D1214, 16'h1234, 2'b01, 5'd5);
    check("post_rst_corr", {24'd0, corr_cnt}, 32'd1);

    // Saturation of the uncorrectable counter
    for (int k = 0; k < 300; k++) begin
      send_bits(24'h4D1237, 24);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
    end
    check("sat_uncorr", {24'd0, uncorr_cnt}, 32'd255);
    check("sat_corr", {24'd0, corr_cnt}, 32'd1);
    check("sat_status", {30'd0, status}, 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
